picobello_mesh_link: RTL

Parametrised, buffered, unidirectional inter-tile mesh link carrying `NumChannels` independent valid/ready flit channels. Each channel has a `Depth`-entry FIFO. A link-level isolation state machine drains in-flight flits and then fences the link. It sits between a tile's `floo_*_out[X][Y][Dir]` and the neighbour's `floo_*_in[Xn][Yn][opposite]` in the mesh top, and replaces the plain wire assignment in the mesh connection loop. Unused mesh edges are fenced via isolation instead of constant tie-off.

---
 rtl/picobello_pkg.sv | 12 +
 rtl/picobello_link_fifo.sv | 66 ++++++
 rtl/picobello_mesh_link.sv | 124 ++++++++++++
 3 files changed

// File: rtl/picobello_pkg.sv
// Shared types for the picobello mesh link: isolation FSM states and default FIFO depth.
package picobello_pkg;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } mesh_link_state_e;

    localparam int unsigned MeshLinkDepth = 2;

endpackage

// File: rtl/picobello_link_fifo.sv
// Single-channel flit FIFO without fall-through; pointers wrap modulo Depth (any Depth >= 1).
module picobello_link_fifo #(
    parameter int unsigned FlitWidth = 64,
    parameter int unsigned Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [FlitWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [FlitWidth-1:0] data_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [FlitWidth-1:0] r_mem [Depth];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [CntW-1:0]      r_cnt;
    logic                 w_push;
    logic                 w_pop;

    assign full_o  = (r_cnt == DepthCnt);
    assign empty_o = (r_cnt == {CntW{1'b0}});
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rptr];

    // Storage array; cleared on reset so an idle egress shows zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= {FlitWidth{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= {PtrW{1'b0}};
            r_rptr <= {PtrW{1'b0}};
            r_cnt  <= {CntW{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LastPtr) ? {PtrW{1'b0}} : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? {PtrW{1'b0}} : r_rptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/picobello_mesh_link.sv
// Buffered multi-channel mesh link with drain-then-fence isolation FSM.
// Optional egress flit counters are built when PB_MESH_LINK_PERF_EN is defined.
module picobello_mesh_link
    import picobello_pkg::*;
#(
    parameter int unsigned NumChannels = 3,
    parameter int unsigned FlitWidth   = 64,
    parameter int unsigned Depth       = 2,
    parameter int unsigned CntWidth    = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumChannels-1:0]                in_valid_i,
    output logic [NumChannels-1:0]                in_ready_o,
    input  logic [NumChannels-1:0][FlitWidth-1:0] in_data_i,
    output logic [NumChannels-1:0]                out_valid_o,
    input  logic [NumChannels-1:0]                out_ready_i,
    output logic [NumChannels-1:0][FlitWidth-1:0] out_data_o,
    input  logic                                  isolate_req_i,
    output logic                                  isolate_ack_o,
    output logic                                  busy_o,
    input  logic                                  perf_clear_i,
    output logic [NumChannels-1:0][CntWidth-1:0]  perf_cnt_o
);

    mesh_link_state_e        r_state;
    mesh_link_state_e        w_state_next;
    logic [NumChannels-1:0]  w_full;
    logic [NumChannels-1:0]  w_empty;
    logic [NumChannels-1:0]  w_push;
    logic [NumChannels-1:0]  w_pop;

    assign in_ready_o    = ~w_full & {NumChannels{r_state == ACTIVE}};
    assign out_valid_o   = ~w_empty;
    assign w_push        = in_valid_i & in_ready_o;
    assign w_pop         = out_valid_o & out_ready_i;
    assign busy_o        = |(~w_empty);
    assign isolate_ack_o = (r_state == ISOLATED);

    for (genvar c = 0; c < int'(NumChannels); c++) begin : g_chan
        picobello_link_fifo #(
            .FlitWidth (FlitWidth),
            .Depth     (Depth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (w_push[c]),
            .data_i  (in_data_i[c]),
            .pop_i   (w_pop[c]),
            .full_o  (w_full[c]),
            .empty_o (w_empty[c]),
            .data_o  (out_data_o[c])
        );
    end

    // Isolation state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ACTIVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Isolation next-state: drain completes on registered empty flags; a dropped request aborts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACTIVE: begin
                if (isolate_req_i) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = ACTIVE;
                end
            end
            DRAIN: begin
                if (!isolate_req_i) begin
                    w_state_next = ACTIVE;
                end else if (&w_empty) begin
                    w_state_next = ISOLATED;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            ISOLATED: begin
                if (!isolate_req_i) begin
                    w_state_next = ACTIVE;
                end else begin
                    w_state_next = ISOLATED;
                end
            end
            default: w_state_next = ACTIVE;
        endcase
    end

`ifdef PB_MESH_LINK_PERF_EN
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [NumChannels-1:0][CntWidth-1:0] r_perf_cnt;

    // Saturating egress handshake counters; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_cnt <= '0;
        end else begin
            for (int c = 0; c < int'(NumChannels); c++) begin
                if (perf_clear_i) begin
                    r_perf_cnt[c] <= {CntWidth{1'b0}};
                end else if (w_pop[c] && (r_perf_cnt[c] != CntMax)) begin
                    r_perf_cnt[c] <= r_perf_cnt[c] + CntWidth'(1);
                end
            end
        end
    end

    assign perf_cnt_o = r_perf_cnt;
`else
    logic w_unused_perf_clear;

    assign w_unused_perf_clear = perf_clear_i;
    assign perf_cnt_o          = '0;
`endif

endmodule
